// File: rtl/rst_mc_pkg.sv
// Shared types and helpers for the register status (rename) table.
// Tag and channel widths here are upper bounds; instances zero-extend into them.
package rst_mc_pkg;

   localparam int TAG_MAX = 16;
   localparam int CDB_MAX = 8;

   typedef struct packed {
      logic               pend;
      logic [TAG_MAX-1:0] tag;
   } entry_t;

   function automatic int addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic cdb_hit(input logic [TAG_MAX-1:0]         tag,
                                    input logic [CDB_MAX-1:0]         valid,
                                    input logic [CDB_MAX*TAG_MAX-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < CDB_MAX; c++)
         hit |= valid[c] & (tags[c*TAG_MAX +: TAG_MAX] == tag);
      return hit;
   endfunction

endpackage

// File: rtl/rst_mc_cmp.sv
// Multi-channel CDB tag comparator for a single table or snapshot entry.
module rst_mc_cmp
   import rst_mc_pkg::*;
#(
   parameter int TAG_W   = 5,
   parameter int NUM_CDB = 2
) (
   input  logic                     pend,
   input  logic [TAG_W-1:0]         tag,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
   output logic                     hit
);

   entry_t                     ent;
   logic [CDB_MAX-1:0]         vld_x;
   logic [CDB_MAX*TAG_MAX-1:0] tags_x;

   // Unused upper channels stay invalid, so padding never produces a hit.
   always_comb begin
      ent                 = '0;
      ent.pend            = pend;
      ent.tag[TAG_W-1:0]  = tag;
      vld_x               = '0;
      vld_x[NUM_CDB-1:0]  = cdb_valid;
      tags_x              = '0;
      for (int c = 0; c < NUM_CDB; c++)
         tags_x[c*TAG_MAX +: TAG_W] = cdb_tag[c*TAG_W +: TAG_W];
      hit = ent.pend & cdb_hit(ent.tag, vld_x, tags_x);
   end

endmodule

// File: rtl/rst_mc.sv
// Register status table with multi-CDB wakeup, read bypass and branch
// checkpoints that keep tracking broadcasts while they are live.
module rst_mc
   import rst_mc_pkg::*;
#(
   parameter int NUM_REGS  = 32,
   parameter int TAG_W     = 5,
   parameter int NUM_RD    = 2,
   parameter int NUM_CDB   = 2,
   parameter int NUM_CKPT  = 4,
   parameter int ZERO_HARD = 1,
   localparam int AW = addr_w(NUM_REGS),
   localparam int CW = addr_w(NUM_CKPT)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*TAG_W-1:0]  rd_tag,
   output logic [NUM_RD-1:0]        rd_pend,
   input  logic                     wen,
   input  logic [AW-1:0]            waddr,
   input  logic [TAG_W-1:0]         wtag,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
   input  logic                     ckpt_save,
   input  logic [CW-1:0]            ckpt_save_id,
   input  logic                     ckpt_restore,
   input  logic [CW-1:0]            ckpt_restore_id,
   input  logic [NUM_CKPT-1:0]      ckpt_free,
   input  logic                     flush,
   output logic [NUM_CKPT-1:0]      ckpt_live,
   output logic [NUM_REGS-1:0]      clr_vec
);

   logic [NUM_REGS-1:0] pend_q;
   logic [TAG_W-1:0]    tag_q  [NUM_REGS];
   logic [NUM_REGS-1:0] cp_pend [NUM_CKPT];
   logic [TAG_W-1:0]    cp_tag  [NUM_CKPT][NUM_REGS];
   logic [NUM_CKPT-1:0] live_q;

   logic [NUM_REGS-1:0] t_hit;
   logic                c_hit [NUM_CKPT][NUM_REGS];
   logic [NUM_RD-1:0]   r_hit;

   logic [NUM_REGS-1:0] nx_pend;
   logic [TAG_W-1:0]    nx_tag [NUM_REGS];
   logic [NUM_REGS-1:0] rs_pend;
   logic [TAG_W-1:0]    rs_tag [NUM_REGS];

   logic zero_wr;
   logic wen_eff;
   logic save_eff;

   assign zero_wr  = (ZERO_HARD != 0) && (waddr == '0);
   assign wen_eff  = wen && !zero_wr;
   assign save_eff = ckpt_save && !ckpt_restore;
   assign ckpt_live = live_q;

   for (genvar e = 0; e < NUM_REGS; e++) begin : g_ent
      rst_mc_cmp #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_cmp (
         .pend      (pend_q[e]),
         .tag       (tag_q[e]),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .hit       (t_hit[e])
      );
      for (genvar k = 0; k < NUM_CKPT; k++) begin : g_ck
         rst_mc_cmp #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_cmp (
            .pend      (cp_pend[k][e]),
            .tag       (cp_tag[k][e]),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .hit       (c_hit[k][e])
         );
      end
   end

   // Reads see pre-write state; a matching broadcast this cycle hides pending.
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[i*AW +: AW];
      rst_mc_cmp #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_cmp (
         .pend      (pend_q[ra]),
         .tag       (tag_q[ra]),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .hit       (r_hit[i])
      );
      assign rd_pend[i]                = pend_q[ra] & ~r_hit[i];
      assign rd_tag[i*TAG_W +: TAG_W]  = tag_q[ra];
   end

   always_comb begin
      for (int e = 0; e < NUM_REGS; e++) begin
         clr_vec[e] = t_hit[e] & ~(wen && (waddr == AW'(e)));
         nx_pend[e] = pend_q[e];
         nx_tag[e]  = tag_q[e];
         if (wen_eff && (waddr == AW'(e))) begin
            nx_pend[e] = 1'b1;
            nx_tag[e]  = wtag;
         end else if (clr_vec[e]) begin
            nx_pend[e] = 1'b0;
            nx_tag[e]  = '0;
         end
         rs_pend[e] = cp_pend[ckpt_restore_id][e] & ~c_hit[ckpt_restore_id][e];
         rs_tag[e]  = c_hit[ckpt_restore_id][e] ? '0 : cp_tag[ckpt_restore_id][e];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend_q  <= '0;
         tag_q   <= '{default: '0};
         cp_pend <= '{default: '0};
         cp_tag  <= '{default: '0};
         live_q  <= '0;
      end else if (flush) begin
         pend_q  <= '0;
         tag_q   <= '{default: '0};
         cp_pend <= '{default: '0};
         cp_tag  <= '{default: '0};
         live_q  <= '0;
      end else begin
         if (ckpt_restore) begin
            pend_q <= rs_pend;
            tag_q  <= rs_tag;
         end else begin
            pend_q <= nx_pend;
            tag_q  <= nx_tag;
         end
         // Snapshots hold the post-edge table; live ones keep absorbing broadcasts.
         for (int k = 0; k < NUM_CKPT; k++) begin
            if (save_eff && (ckpt_save_id == CW'(k))) begin
               cp_pend[k] <= nx_pend;
               cp_tag[k]  <= nx_tag;
               live_q[k]  <= 1'b1;
            end else begin
               if (live_q[k]) begin
                  for (int e = 0; e < NUM_REGS; e++) begin
                     if (c_hit[k][e]) begin
                        cp_pend[k][e] <= 1'b0;
                        cp_tag[k][e]  <= '0;
                     end
                  end
               end
               if (ckpt_free[k] || (ckpt_restore && (ckpt_restore_id == CW'(k))))
                  live_q[k] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rst_mc.sv
// Randomized and directed bench for rst_mc against a tag-set reference model.
module tb_rst_mc;
   import rst_mc_pkg::*;

   localparam int NUM_REGS = 32;
   localparam int TAG_W    = 5;
   localparam int NUM_RD   = 2;
   localparam int NUM_CDB  = 2;
   localparam int NUM_CKPT = 4;
   localparam int AW       = 5;
   localparam int CW       = 2;
   localparam int NTAGS    = 1 << TAG_W;

   logic                     clock = 1'b0;
   logic                     reset;
   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*TAG_W-1:0]  rd_tag;
   logic [NUM_RD-1:0]        rd_pend;
   logic                     wen;
   logic [AW-1:0]            waddr;
   logic [TAG_W-1:0]         wtag;
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*TAG_W-1:0] cdb_tag;
   logic                     ckpt_save;
   logic [CW-1:0]            ckpt_save_id;
   logic                     ckpt_restore;
   logic [CW-1:0]            ckpt_restore_id;
   logic [NUM_CKPT-1:0]      ckpt_free;
   logic                     flush;
   logic [NUM_CKPT-1:0]      ckpt_live;
   logic [NUM_REGS-1:0]      clr_vec;

   rst_mc #(
      .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_RD(NUM_RD),
      .NUM_CDB(NUM_CDB), .NUM_CKPT(NUM_CKPT), .ZERO_HARD(1)
   ) dut (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_tag(rd_tag),
      .rd_pend(rd_pend), .wen(wen), .waddr(waddr), .wtag(wtag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .ckpt_save(ckpt_save),
      .ckpt_save_id(ckpt_save_id), .ckpt_restore(ckpt_restore),
      .ckpt_restore_id(ckpt_restore_id), .ckpt_free(ckpt_free),
      .flush(flush), .ckpt_live(ckpt_live), .clr_vec(clr_vec)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: plain arrays of pending flags and tags.
   bit m_pend [NUM_REGS];
   int m_tag  [NUM_REGS];
   bit s_pend [NUM_CKPT][NUM_REGS];
   int s_tag  [NUM_CKPT][NUM_REGS];
   bit m_live [NUM_CKPT];
   bit bcast  [NTAGS];

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle();
      rd_addr = '0; wen = 0; waddr = '0; wtag = '0;
      cdb_valid = '0; cdb_tag = '0;
      ckpt_save = 0; ckpt_save_id = '0; ckpt_restore = 0; ckpt_restore_id = '0;
      ckpt_free = '0; flush = 0;
   endtask

   task automatic set_rd(input int i, input int a);
      rd_addr[i*AW +: AW] = AW'(a);
   endtask

   task automatic set_cdb(input int c, input int t);
      cdb_valid[c] = 1'b1;
      cdb_tag[c*TAG_W +: TAG_W] = TAG_W'(t);
   endtask

   function automatic void model_reset();
      for (int e = 0; e < NUM_REGS; e++) begin
         m_pend[e] = 0; m_tag[e] = 0;
         for (int k = 0; k < NUM_CKPT; k++) begin s_pend[k][e] = 0; s_tag[k][e] = 0; end
      end
      for (int k = 0; k < NUM_CKPT; k++) m_live[k] = 0;
   endfunction

   // Set of tags broadcast this cycle; any pending holder of one is satisfied.
   function automatic void build_bcast();
      for (int t = 0; t < NTAGS; t++) bcast[t] = 0;
      for (int c = 0; c < NUM_CDB; c++)
         if (cdb_valid[c]) bcast[int'(cdb_tag[c*TAG_W +: TAG_W])] = 1;
   endfunction

   task automatic check_outputs();
      logic [NUM_REGS-1:0] ec;
      logic [NUM_CKPT-1:0] el;
      build_bcast();
      for (int i = 0; i < NUM_RD; i++) begin
         int a;
         a = int'(rd_addr[i*AW +: AW]);
         check_val($sformatf("rd_pend%0d", i), 64'(rd_pend[i]), 64'(m_pend[a] && !bcast[m_tag[a]]));
         check_val($sformatf("rd_tag%0d", i), 64'(rd_tag[i*TAG_W +: TAG_W]), 64'(m_tag[a]));
      end
      for (int e = 0; e < NUM_REGS; e++)
         ec[e] = m_pend[e] && bcast[m_tag[e]] && !(wen && int'(waddr) == e);
      check_val("clr_vec", 64'(clr_vec), 64'(ec));
      for (int k = 0; k < NUM_CKPT; k++) el[k] = m_live[k];
      check_val("ckpt_live", 64'(ckpt_live), 64'(el));
   endtask

   function automatic void model_step();
      bit np [NUM_REGS];
      int nt [NUM_REGS];
      int rid, sid;
      rid = int'(ckpt_restore_id);
      sid = int'(ckpt_save_id);
      if (flush) begin
         model_reset();
         return;
      end
      for (int e = 0; e < NUM_REGS; e++) begin
         if (ckpt_restore) begin
            np[e] = s_pend[rid][e] && !bcast[s_tag[rid][e]];
            nt[e] = (s_pend[rid][e] && bcast[s_tag[rid][e]]) ? 0 : s_tag[rid][e];
         end else if (wen && int'(waddr) == e && e != 0) begin
            np[e] = 1; nt[e] = int'(wtag);
         end else if (m_pend[e] && bcast[m_tag[e]]) begin
            np[e] = 0; nt[e] = 0;
         end else begin
            np[e] = m_pend[e]; nt[e] = m_tag[e];
         end
      end
      for (int k = 0; k < NUM_CKPT; k++) begin
         if (ckpt_save && !ckpt_restore && sid == k) begin
            s_pend[k] = np; s_tag[k] = nt; m_live[k] = 1;
         end else begin
            if (m_live[k])
               for (int e = 0; e < NUM_REGS; e++)
                  if (s_pend[k][e] && bcast[s_tag[k][e]]) begin s_pend[k][e] = 0; s_tag[k][e] = 0; end
            if (ckpt_free[k] || (ckpt_restore && rid == k)) m_live[k] = 0;
         end
      end
      m_pend = np;
      m_tag  = nt;
   endfunction

   // Called just after a falling edge with inputs set; returns at the next one.
   task automatic tick();
      #1;
      check_outputs();
      model_step();
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      model_reset();
      set_rd(0, 3); set_rd(1, 17);
      #1;
      check_val("rst_pend", 64'(rd_pend), 64'd0);
      check_val("rst_tag",  64'(rd_tag), 64'd0);
      check_val("rst_clr",  64'(clr_vec), 64'd0);
      check_val("rst_live", 64'(ckpt_live), 64'd0);
      @(negedge clock); @(negedge clock);
      reset = 1'b0;

      // Rename, read back, then CDB bypass and clear.
      idle(); wen = 1; waddr = 3; wtag = 7; tick();
      idle(); set_rd(0, 3); #1;
      check_val("t1_pend", 64'(rd_pend[0]), 64'd1);
      check_val("t1_tag",  64'(rd_tag[TAG_W-1:0]), 64'd7);
      tick();
      idle(); set_rd(0, 3); set_cdb(0, 7); #1;
      check_val("t1_bypass", 64'(rd_pend[0]), 64'd0);
      check_val("t1_bytag",  64'(rd_tag[TAG_W-1:0]), 64'd7);
      check_val("t1_clr3",   64'(clr_vec[3]), 64'd1);
      tick();
      idle(); set_rd(0, 3); #1;
      check_val("t1_cleared", 64'({rd_pend[0], rd_tag[TAG_W-1:0]}), 64'd0);
      tick();

      // Write beats same-cycle clear; two channels clear two entries.
      idle(); wen = 1; waddr = 5; wtag = 9; tick();
      idle(); wen = 1; waddr = 5; wtag = 12; set_cdb(0, 9); #1;
      check_val("t2_noclr", 64'(clr_vec[5]), 64'd0);
      tick();
      idle(); set_rd(0, 5); wen = 1; waddr = 6; wtag = 9; #1;
      check_val("t2_r5", 64'({rd_pend[0], rd_tag[TAG_W-1:0]}), 64'h2c);
      tick();
      idle(); set_cdb(0, 9); set_cdb(1, 12); #1;
      check_val("t2_clr56", 64'(clr_vec[6:5]), 64'd3);
      tick();
      idle(); set_rd(0, 5); set_rd(1, 6); tick();

      // Register 0 is never renamed.
      idle(); wen = 1; waddr = 0; wtag = 4; tick();
      idle(); set_rd(0, 0); #1;
      check_val("t3_r0", 64'({rd_pend[0], rd_tag[TAG_W-1:0]}), 64'd0);
      tick();

      // Save with write, then restore under a CDB clear.
      idle(); wen = 1; waddr = 2; wtag = 3; tick();
      idle(); ckpt_save = 1; ckpt_save_id = 1; wen = 1; waddr = 4; wtag = 8; tick();
      idle(); wen = 1; waddr = 4; wtag = 10; set_cdb(0, 3);
      ckpt_restore = 1; ckpt_restore_id = 1; tick();
      idle(); set_rd(0, 2); set_rd(1, 4); #1;
      check_val("t4_r2", 64'({rd_pend[0], rd_tag[TAG_W-1:0]}), 64'd0);
      check_val("t4_r4", 64'({rd_pend[1], rd_tag[2*TAG_W-1:TAG_W]}), 64'h28);
      check_val("t4_live1", 64'(ckpt_live[1]), 64'd0);
      tick();

      // Restore ignores concurrent write and save.
      idle(); ckpt_save = 1; ckpt_save_id = 2; tick();
      idle(); ckpt_restore = 1; ckpt_restore_id = 2; wen = 1; waddr = 6; wtag = 11;
      ckpt_save = 1; ckpt_save_id = 0; tick();
      idle(); set_rd(0, 6); #1;
      check_val("t5_r6", 64'(rd_pend[0]), 64'd0);
      check_val("t5_live", 64'(ckpt_live), 64'd0);
      tick();

      // Flush clears everything, then asynchronous reset mid-run.
      idle(); wen = 1; waddr = 1; wtag = 20; ckpt_save = 1; ckpt_save_id = 0; tick();
      idle(); wen = 1; waddr = 7; wtag = 21; ckpt_save = 1; ckpt_save_id = 1; tick();
      idle(); ckpt_save = 1; ckpt_save_id = 3; tick();
      idle(); set_rd(0, 1); set_rd(1, 7); wen = 1; waddr = 8; wtag = 22; flush = 1; #1;
      check_val("t6_live_pre", 64'(ckpt_live), 64'b1011);
      tick();
      idle(); set_rd(0, 7); set_rd(1, 8); #1;
      check_val("t6_flush_pend", 64'(rd_pend), 64'd0);
      check_val("t6_flush_live", 64'(ckpt_live), 64'd0);
      tick();
      idle(); wen = 1; waddr = 9; wtag = 23; ckpt_save = 1; ckpt_save_id = 2; tick();
      idle(); set_rd(0, 9); #1;
      check_val("t6_pre_rst", 64'(rd_pend[0]), 64'd1);
      #1 reset = 1'b1;
      #1;
      check_val("t6_rst_pend", 64'(rd_pend), 64'd0);
      check_val("t6_rst_tag",  64'(rd_tag), 64'd0);
      check_val("t6_rst_live", 64'(ckpt_live), 64'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;

      // Random traffic, CDB tags biased toward tags currently in flight.
      for (int n = 0; n < 2000; n++) begin
         idle();
         rd_addr = NUM_RD*AW'($urandom);
         wen   = 1'($urandom_range(0, 1));
         waddr = AW'($urandom);
         wtag  = TAG_W'($urandom);
         for (int c = 0; c < NUM_CDB; c++) begin
            cdb_valid[c] = ($urandom_range(0, 2) != 0);
            cdb_tag[c*TAG_W +: TAG_W] = ($urandom_range(0, 3) != 0) ?
               TAG_W'(m_tag[$urandom_range(0, NUM_REGS-1)]) : TAG_W'($urandom);
         end
         ckpt_save    = ($urandom_range(0, 7) == 0);
         ckpt_save_id = CW'($urandom);
         ckpt_restore_id = CW'($urandom);
         ckpt_restore = ($urandom_range(0, 9) == 0) && m_live[int'(ckpt_restore_id)];
         ckpt_free    = ($urandom_range(0, 9) == 0) ? NUM_CKPT'($urandom) : '0;
         flush        = ($urandom_range(0, 149) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rst_mc.md
Name: rst_mc

Overview:
- Parametrised Register Status Table (rename map) for the Tomasulo/ROB core; next generation of the single-CDB table.
- Per architectural register, holds {pending, ROB tag}.
- Supports N read ports, M CDB broadcast channels with same-cycle bypass, and K branch checkpoints with restore.
- Sits between decode/dispatch, the CDB and the branch/exception recovery logic.

Parameters:
- NUM_REGS, 32, architectural registers (power of 2, >=2); AW = log2(NUM_REGS) is a derived localparam.
- TAG_W, 5, ROB tag width.
- NUM_RD, 2, read ports (Rs, Rt per issue slot).
- NUM_CDB, 2, CDB broadcast channels.
- NUM_CKPT, 4, checkpoint slots (>=1); CW = max(1, log2(NUM_CKPT)).
- ZERO_HARD, 1, when 1 register 0 is never renamed.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rd_addr  in  NUM_RD*AW  read addresses; slot i at [i*AW +: AW].
- rd_tag  out  NUM_RD*TAG_W  tag of the entry.
- rd_pend  out  NUM_RD  entry pending (result not yet available).
- wen  in  1  dispatch rename write.
- waddr  in  AW  destination register.
- wtag  in  TAG_W  ROB tag allocated.
- cdb_valid  in  NUM_CDB  broadcast valid per channel.
- cdb_tag  in  NUM_CDB*TAG_W  broadcast tags.
- ckpt_save  in  1  snapshot request.
- ckpt_save_id  in  CW  slot to write.
- ckpt_restore  in  1  recover table from slot.
- ckpt_restore_id  in  CW  slot to read.
- ckpt_free  in  NUM_CKPT  one-hot/multi-hot release of slots.
- flush  in  1  clear entire table and all checkpoints (exception).
- ckpt_live  out  NUM_CKPT  slot holds a valid snapshot.
- clr_vec  out  NUM_REGS  entries cleared by the CDB this cycle (debug/perf).

Behaviour:
- Reset: all entries {pend=0, tag=0}; all checkpoint slots 0; ckpt_live=0. With reset high: rd_pend=0, rd_tag=0, clr_vec=0.
- CDB match, entry e: pend[e] & ∃c: cdb_valid[c] & cdb_tag[c]==tag[e]. clr_vec[e] = match & ~(wen & waddr==e), combinational.
- Normal cycle (no flush, no restore):
  - e <= {1,wtag} if wen & waddr==e (write wins over same-cycle clear of the same entry).
  - Otherwise e <= {0,0} if clr_vec[e].
  - Otherwise hold.
- ZERO_HARD=1: wen with waddr==0 is ignored; entry 0 is constant {0,0}; rd_pend=0 for address 0.
- Read: combinational from current state, 0-cycle latency. A same-cycle wen is not visible (reads see pre-write state).
- CDB bypass: if the addressed entry is pending and its tag matches any valid CDB channel this cycle, rd_pend=0 and rd_tag still shows the tag.
- Multiple CDB channels carrying the same tag: benign, identical to one.
- Checkpoint save: slot ckpt_save_id <= next-state of the table (includes this cycle's write and clears); ckpt_live[id] <= 1. Saving into a live slot overwrites it.
- Live checkpoints track the CDB: each cycle, every live slot clears its pending entries that match any CDB channel. A restored snapshot therefore never waits on an already-broadcast tag.
- Restore: table <= slot contents with this cycle's CDB clears applied. wen and ckpt_save are ignored that cycle. ckpt_live[restore_id] <= 0. Restoring a non-live slot is a caller error; the table still loads the slot contents.
- ckpt_free: ckpt_live[i] <= 0 for each set bit. Save to the same id in the same cycle wins (slot live).
- Flush: all entries and all slots <= 0, ckpt_live <= 0. Highest priority, overrides restore, save, wen and CDB.
- Priority summary: reset > flush > restore > {wen over CDB clear, save}.
- Reset asserted mid-operation: immediate asynchronous clear of all state; no partial snapshot survives.

Decomposition:
- Package rst_mc_pkg:
  - entry struct {pend, tag};
  - function cdb_hit(tag, cdb_valid, cdb_tag) returning the match bit;
  - localparam helpers for AW/CW.
- One sub-module rst_mc_cmp: NUM_CDB-way tag comparator for one entry. Instantiated per table entry, per checkpoint entry, and per read port for the bypass.

Test Plan:
1. Reset, then wen waddr=3 wtag=7 → next cycle rd_addr=3 gives rd_pend=1, rd_tag=7. cdb_valid=01, cdb_tag[0]=7 → same cycle rd_pend=0 (bypass); next cycle entry 3 = {0,0}, and clr_vec bit 3 was 1 in the CDB cycle.
2. Entry 5={1,9}; same cycle wen waddr=5 wtag=12 and CDB tag 9 → entry 5={1,12}, clr_vec[5]=0. Two CDB channels carrying tags 9 and 12 to entries 5 and 6 → both cleared in one cycle.
3. ZERO_HARD=1: wen waddr=0 wtag=4 → rd_addr=0 gives rd_pend=0, tag 0.
4. Entry 2={1,3}; ckpt_save id=1 with wen waddr=4 wtag=8 → slot 1 holds r4={1,8}. Then wen r4 tag 10, CDB tag 3, ckpt_restore id=1 → r2={0,0}, r4={1,8}, ckpt_live[1]=0.
5. Restore with simultaneous wen r6 tag 11 and save id=0 → r6 unchanged, ckpt_live[0] unchanged.
6. Table partially pending, ckpt_live=1011, flush with wen active → all rd_pend=0, ckpt_live=0000. Then assert reset mid-run → outputs 0 asynchronously.
